// File: rtl/segment_transition_ctl_if.sv
// Register-file / index-timer side bundle for segment_transition_ctl.
// The master drives the segment request, repeat fields, loop-end pulse, system
// time and GPIO triggers; the slave (the controller) returns segment status.
// Optional debug counter port present only with SEGMENT_TRANSITION_CNT_EN.
interface segment_transition_ctl_if #(
  parameter int REP_WIDTH  = 16,
  parameter int TIME_WIDTH = 64
);
  logic                  update_settings;
  logic                  req_rd_segment;
  logic [7:0]            transition_mode;
  logic [TIME_WIDTH-1:0] transition_value;
  logic [REP_WIDTH-1:0]  rep0;
  logic [REP_WIDTH-1:0]  rep1;
  logic                  loop_end;
  logic [TIME_WIDTH-1:0] sys_time;
  logic [3:0]            gpio_in;
  logic                  segment;
  logic                  swap;
  logic                  stop;
  logic                  pending;
  logic                  bad_mode;
`ifdef SEGMENT_TRANSITION_CNT_EN
  logic [15:0]           swap_cnt;
`endif

  modport master (
    output update_settings, req_rd_segment, transition_mode, transition_value,
           rep0, rep1, loop_end, sys_time, gpio_in,
`ifdef SEGMENT_TRANSITION_CNT_EN
    input  swap_cnt,
`endif
    input  segment, swap, stop, pending, bad_mode
  );

  modport slave (
    input  update_settings, req_rd_segment, transition_mode, transition_value,
           rep0, rep1, loop_end, sys_time, gpio_in,
`ifdef SEGMENT_TRANSITION_CNT_EN
    output swap_cnt,
`endif
    output segment, swap, stop, pending, bad_mode
  );
endinterface

// File: rtl/segment_transition_ctl.sv
// Double-buffered segment read sequencer for one playback engine.
// Tracks the active segment and its loop repetitions, holds a pending segment
// request until its transition condition (loop end, system time, GPIO edge or
// EXT auto-alternation) is met, then swaps the active segment for one cycle.
// Optional: define SEGMENT_TRANSITION_CNT_EN to add a 16-bit swap counter.
module segment_transition_ctl #(
  parameter int REP_WIDTH  = 16,
  parameter int TIME_WIDTH = 64
) (
  input logic clk,
  input logic reset_n,
  segment_transition_ctl_if.slave bus
);
  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;

  // One extra bit so the all-ones code can mean "infinite" without colliding
  // with the largest finite count (REP all-ones minus one, plus one).
  localparam int                   CNT_WIDTH = REP_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_INF   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic {ST_RUN, ST_STOPPED} state_t;

  state_t                state;
  logic                  segment;
  logic                  swap;
  logic                  pending;
  logic                  bad_mode;
  logic                  ext_on;
  logic [CNT_WIDTH-1:0]  loop_cnt;
  logic                  pend_seg;
  logic [7:0]            pend_mode;
  logic [TIME_WIDTH-1:0] pend_value;
  logic [3:0]            gpio_s1, gpio_s2, gpio_s3;

  logic       loop_hit, exhaust, cond, trig, auto_swap, do_swap;
  logic       swap_seg, seg_after, mode_ok, req_same, req_new;
  logic [3:0] gpio_rise;

  function automatic logic [CNT_WIDTH-1:0] load_cnt(input logic [REP_WIDTH-1:0] rep);
    return (&rep) ? CNT_INF : ({1'b0, rep} + CNT_ONE);
  endfunction

  function automatic logic [REP_WIDTH-1:0] rep_of(input logic seg);
    return seg ? bus.rep1 : bus.rep0;
  endfunction

  // GPIO trigger inputs: two-flop synchroniser plus one delay stage for edges.
  // NOTE: async inputs pass through two flops before any logic sees them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
      gpio_s3 <= '0;
    end else begin
      gpio_s1 <= bus.gpio_in;
      gpio_s2 <= gpio_s1;
      gpio_s3 <= gpio_s2;
    end
  end

  // Decide this cycle's loop count, trigger, swap target and request handling.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    cond      = 1'b0;
    gpio_rise = gpio_s2 & ~gpio_s3;
    loop_hit  = bus.loop_end && (state == ST_RUN) && (loop_cnt != CNT_INF);
    exhaust   = loop_hit && (loop_cnt == CNT_ONE);
    case (pend_mode)
      MODE_SYNC_IDX, MODE_EXT: cond = bus.loop_end || (state == ST_STOPPED);
      MODE_SYS_TIME:           cond = (bus.sys_time >= pend_value);
      MODE_GPIO:               cond = gpio_rise[pend_value[1:0]];
      default:                 cond = 1'b0;
    endcase
    trig      = pending && cond;
    auto_swap = !trig && exhaust && ext_on;
    do_swap   = trig || auto_swap;
    swap_seg  = trig ? pend_seg : ~segment;
    seg_after = do_swap ? swap_seg : segment;
    mode_ok   = bus.transition_mode inside {MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT};
    req_same  = bus.update_settings && mode_ok && (bus.req_rd_segment == seg_after);
    req_new   = bus.update_settings && mode_ok && (bus.req_rd_segment != seg_after);
  end

  // RUN/STOPPED FSM with segment, loop counter and pending request registers.
  // A new request is applied after any swap of the same cycle, so it is judged
  // against the post-swap segment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      segment    <= 1'b0;
      swap       <= 1'b0;
      pending    <= 1'b0;
      bad_mode   <= 1'b0;
      ext_on     <= 1'b0;
      loop_cnt   <= CNT_INF;
      pend_seg   <= 1'b0;
      pend_mode  <= MODE_SYNC_IDX;
      pend_value <= '0;
    end else begin
      // NOTE: non-blocking assignments; a later assignment in this block wins.
      swap <= do_swap;
      if (do_swap) begin
        segment  <= swap_seg;
        loop_cnt <= load_cnt(rep_of(swap_seg));
        state    <= ST_RUN;
        pending  <= 1'b0;
        ext_on   <= !trig || (pend_mode == MODE_EXT);
      end else if (loop_hit) begin
        loop_cnt <= loop_cnt - CNT_ONE;
        if (exhaust) state <= ST_STOPPED;
      end

      if (bus.update_settings && !mode_ok) bad_mode <= 1'b1;

      if (req_same) begin
        loop_cnt <= load_cnt(rep_of(seg_after));
        state    <= ST_RUN;
        pending  <= 1'b0;
        ext_on   <= (bus.transition_mode == MODE_EXT);
      end else if (req_new) begin
        pending    <= 1'b1;
        pend_seg   <= bus.req_rd_segment;
        pend_mode  <= bus.transition_mode;
        pend_value <= bus.transition_value;
      end
    end
  end

`ifdef SEGMENT_TRANSITION_CNT_EN
  logic [15:0] swap_cnt;

  // Debug count of segment swaps, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     swap_cnt <= '0;
    else if (do_swap) swap_cnt <= swap_cnt + 16'd1;
  end

  assign bus.swap_cnt = swap_cnt;
`endif

  assign bus.segment  = segment;
  assign bus.swap     = swap;
  assign bus.stop     = (state == ST_STOPPED);
  assign bus.pending  = pending;
  assign bus.bad_mode = bad_mode;
endmodule

// File: tb/tb_segment_transition_ctl.sv
// Testbench for segment_transition_ctl: directed stimulus, a loop-count based
// reference model compared every cycle, and literal timing expectations.
module tb_segment_transition_ctl;
  localparam int RW = 16;
  localparam int TW = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  segment_transition_ctl_if #(.REP_WIDTH(RW), .TIME_WIDTH(TW)) bus ();

  segment_transition_ctl #(.REP_WIDTH(RW), .TIME_WIDTH(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: remaining loop count as an integer (-1 = infinite).
  bit       m_seg = 0, m_swap = 0, m_stop = 0, m_pend = 0, m_bad = 0, m_ext = 0;
  int       m_left = -1;
  bit       p_seg = 0;
  bit [7:0] p_mode = 0;
  bit [63:0] p_val = 0;
  bit [3:0] g_hist [3];

  function automatic int loops_for(input bit seg);
    logic [RW-1:0] rep;
    rep = seg ? bus.rep1 : bus.rep0;
    return (rep == 16'hFFFF) ? -1 : int'(rep) + 1;
  endfunction

  function automatic bit known_mode(input bit [7:0] m);
    return (m == 8'h00) || (m == 8'h01) || (m == 8'h02) || (m == 8'hF0);
  endfunction

  task automatic model_reset();
    m_seg = 0; m_swap = 0; m_stop = 0; m_pend = 0; m_bad = 0; m_ext = 0;
    m_left = -1; p_seg = 0; p_mode = 0; p_val = 0;
    for (int i = 0; i < 3; i++) g_hist[i] = '0;
  endtask

  task automatic model_step();
    bit cond, fire, next_swap;
    int sel;
    sel = int'(p_val[1:0]);
    case (p_mode)
      8'h00, 8'hF0: cond = bus.loop_end || m_stop;
      8'h01:        cond = (bus.sys_time >= p_val);
      8'h02:        cond = g_hist[1][sel] && !g_hist[2][sel];
      default:      cond = 0;
    endcase
    fire = m_pend && cond;
    next_swap = 0;
    if (fire) begin
      m_seg = p_seg; m_left = loops_for(p_seg); m_stop = 0; m_pend = 0;
      m_ext = (p_mode == 8'hF0); next_swap = 1;
    end else if (bus.loop_end && !m_stop && m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_ext) begin
          m_seg = !m_seg; m_left = loops_for(m_seg); next_swap = 1;
        end else begin
          m_stop = 1;
        end
      end
    end
    if (bus.update_settings) begin
      if (!known_mode(bus.transition_mode)) m_bad = 1;
      else if (bus.req_rd_segment == m_seg) begin
        m_left = loops_for(m_seg); m_stop = 0; m_pend = 0;
        m_ext = (bus.transition_mode == 8'hF0);
      end else begin
        m_pend = 1; p_seg = bus.req_rd_segment;
        p_mode = bus.transition_mode; p_val = bus.transition_value;
      end
    end
    m_swap = next_swap;
    g_hist[2] = g_hist[1];
    g_hist[1] = g_hist[0];
    g_hist[0] = bus.gpio_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("mdl_segment", bus.segment, m_seg);
      check("mdl_swap", bus.swap, m_swap);
      check("mdl_stop", bus.stop, m_stop);
      check("mdl_pending", bus.pending, m_pend);
      check("mdl_bad_mode", bus.bad_mode, m_bad);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_loop();
    bus.loop_end = 1'b1;
    tick();
    bus.loop_end = 1'b0;
  endtask

  task automatic request(input bit seg, input bit [7:0] mode, input bit [63:0] value);
    bus.update_settings  = 1'b1;
    bus.req_rd_segment   = seg;
    bus.transition_mode  = mode;
    bus.transition_value = value;
    tick();
    bus.update_settings = 1'b0;
  endtask

  initial begin
    bus.update_settings = 0; bus.req_rd_segment = 0; bus.transition_mode = 0;
    bus.transition_value = 0; bus.rep0 = 16'hFFFF; bus.rep1 = 16'hFFFF;
    bus.loop_end = 0; bus.sys_time = 0; bus.gpio_in = 0;
    tick(); tick();
    check("rst_segment", bus.segment, 0);
    check("rst_stop", bus.stop, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_bad_mode", bus.bad_mode, 0);
    reset_n = 1'b1;
    tick();

    // Infinite repeat: loop ends never stop or swap.
    for (int i = 0; i < 10; i++) begin
      pulse_loop();
      check("inf_swap", bus.swap, 0);
      tick();
    end
    check("inf_segment", bus.segment, 0);
    check("inf_stop", bus.stop, 0);

    // Same-segment reload with REP0=2 gives three loops, then STOP.
    bus.rep0 = 16'd2;
    request(0, 8'h00, 0);
    check("reload_pending", bus.pending, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse_loop();
      check("rep2_stop", bus.stop, (i == 3));
      tick();
    end
    request(0, 8'h00, 0);
    check("reload_clears_stop", bus.stop, 0);
    check("reload_no_swap", bus.swap, 0);

    // SYNC_IDX swap to segment 1 on the next loop end; REP1=0 stops after one loop.
    bus.rep1 = 16'd0;
    request(1, 8'h00, 0);
    check("sync_pending", bus.pending, 1);
    tick(); tick();
    check("sync_wait_segment", bus.segment, 0);
    pulse_loop();
    check("sync_segment", bus.segment, 1);
    check("sync_swap", bus.swap, 1);
    tick();
    check("sync_swap_one_cycle", bus.swap, 0);
    pulse_loop();
    check("sync_rep0_stop", bus.stop, 1);
    tick();

    // SYS_TIME threshold 1000 with a ramp from 990.
    bus.rep0 = 16'hFFFF;
    bus.sys_time = 64'd990;
    request(0, 8'h01, 64'd1000);
    for (int t = 991; t <= 1000; t++) begin
      bus.sys_time = 64'(t);
      tick();
      check("systime_swap", bus.swap, (t == 1000));
    end
    check("systime_segment", bus.segment, 0);
    check("systime_stop_cleared", bus.stop, 0);
    bus.sys_time = 64'd1001;
    request(1, 8'h01, 64'd5);
    check("past_no_swap_yet", bus.swap, 0);
    tick();
    check("past_swap", bus.swap, 1);
    check("past_segment", bus.segment, 1);

    // GPIO select 2: a bit-1 pulse is ignored, bit-2 edge swaps 3 cycles later.
    request(0, 8'h02, 64'd2);
    bus.gpio_in = 4'b0010;
    tick();
    bus.gpio_in = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gpio_wrong_bit", bus.swap, 0);
    end
    bus.gpio_in = 4'b0100;
    tick();
    check("gpio_lat1", bus.swap, 0);
    tick();
    check("gpio_lat2", bus.swap, 0);
    bus.gpio_in = 4'b0000;
    tick();
    check("gpio_lat3_swap", bus.swap, 1);
    check("gpio_segment", bus.segment, 0);
    tick();

    // EXT alternation: segment 1 for one loop, segment 0 for two.
    bus.rep0 = 16'd1;
    bus.rep1 = 16'd0;
    request(1, 8'hF0, 0);
    begin
      bit exp_seg [5] = '{1, 0, 0, 1, 0};
      bit exp_swp [5] = '{1, 1, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
        pulse_loop();
        check("ext_segment", bus.segment, exp_seg[i]);
        check("ext_swap", bus.swap, exp_swp[i]);
        tick();
      end
    end

    // Unknown mode: sticky BAD_MODE, nothing else moves.
    request(1, 8'h07, 0);
    check("bad_mode_set", bus.bad_mode, 1);
    check("bad_mode_no_pending", bus.pending, 0);
    check("bad_mode_segment", bus.segment, 0);
    tick();

    // Reset while a request is pending.
    request(1, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF);
    check("pre_reset_pending", bus.pending, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_segment", bus.segment, 0);
    check("midrst_pending", bus.pending, 0);
    check("midrst_bad_mode", bus.bad_mode, 0);
    check("midrst_stop", bus.stop, 0);
    tick();
    reset_n = 1'b1;
    bus.rep0 = 16'hFFFF;
    bus.rep1 = 16'hFFFF;
    tick();

    // LOOP_END with the request does not count; a later loop end triggers.
    bus.loop_end = 1'b1;
    request(1, 8'h00, 0);
    bus.loop_end = 1'b0;
    check("same_cycle_no_swap", bus.swap, 0);
    check("same_cycle_pending", bus.pending, 1);
    tick();
    check("same_cycle_still_waiting", bus.swap, 0);
    pulse_loop();
    check("late_loop_swap", bus.swap, 1);
    check("late_loop_segment", bus.segment, 1);
    tick();

    // Request arriving with a swap is judged against the new segment.
    request(0, 8'h00, 0);
    bus.loop_end = 1'b1;
    request(1, 8'h00, 0);
    bus.loop_end = 1'b0;
    check("swap_and_req_segment", bus.segment, 0);
    check("swap_and_req_pending", bus.pending, 1);
    pulse_loop();
    check("swap_and_req_final", bus.segment, 1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/segment_transition_ctl.md
Name: segment_transition_ctl

Overview:
- Sequences the double-buffered segment read path for one playback engine (modulation or STM); one instance per engine.
- Tracks the active read segment and counts loop repetitions.
- Holds a pending segment request until its transition condition is met, then swaps the active segment on a single cycle.
- Sits between the controller register file (REQ_RD_SEGMENT, REP0/1, TRANSITION_MODE/VALUE) and the engine's index timer and memory read mux.

Parameters:
- REP_WIDTH, 16, width of the repeat fields; all-ones means infinite.
- TIME_WIDTH, 64, width of the system time and of the transition value.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- UPDATE_SETTINGS  in  1  one-cycle pulse; latch the request inputs below
- REQ_RD_SEGMENT  in  1  requested read segment
- TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
- TRANSITION_VALUE  in  TIME_WIDTH  SYS_TIME threshold, or GPIO select in [1:0]
- REP0  in  REP_WIDTH  repeat field for segment 0
- REP1  in  REP_WIDTH  repeat field for segment 1
- LOOP_END  in  1  pulse from the index timer when the index wraps cycle-1 → 0
- SYS_TIME  in  TIME_WIDTH  free-running synchronised system time
- GPIO_IN  in  4  asynchronous external trigger inputs
- SEGMENT  out  1  active read segment
- SWAP  out  1  one-cycle pulse on the cycle SEGMENT changes
- STOP  out  1  repeat count exhausted; engine holds its last sample
- PENDING  out  1  a request is waiting for its condition
- BAD_MODE  out  1  sticky; set when a request carries an unknown mode

Behaviour:
- Reset (async, RESET_N low): SEGMENT=0, SWAP=0, STOP=0, PENDING=0, BAD_MODE=0, EXT auto-alternation off, loop counter infinite.
- Repeat encoding: REP = all-ones means infinite; otherwise loops = REP+1. The loop counter is REP_WIDTH+1 bits wide.
- States:
  - RUN: on LOOP_END with a finite count, decrement. On reaching zero:
    - if EXT is active, swap to the other segment and load that segment's REP;
    - else → STOPPED (STOP=1).
  - STOPPED: LOOP_END is ignored. STOP stays 1 until a swap or a same-segment reload.
  - PENDING is an orthogonal flag, not a state: the RUN/STOPPED behaviour continues while a request waits.
- Request latch on UPDATE_SETTINGS:
  - Unknown mode: request discarded, BAD_MODE set, nothing else changes.
  - REQ_RD_SEGMENT == SEGMENT: the next cycle reloads the loop counter from that segment's REP, clears STOP, and clears any pending request. No SWAP pulse. EXT takes the new mode (on only if mode is EXT).
  - Otherwise: latch segment, mode and value; PENDING=1. A later UPDATE_SETTINGS replaces an earlier pending request.
- Trigger conditions, evaluated from the cycle after the latch:
  - SYNC_IDX: the next LOOP_END, or the immediately following cycle if STOPPED.
  - SYS_TIME: unsigned SYS_TIME >= VALUE; a threshold already in the past fires on the first evaluation cycle.
  - GPIO: rising edge of GPIO_IN[VALUE[1:0]] after a 2-flop synchroniser; GPIO-to-trigger latency is 3 cycles.
  - EXT: the next LOOP_END (or immediately if STOPPED); sets auto-alternation.
- Swap, registered, fires on the cycle after the trigger condition is seen:
  - SEGMENT ← requested segment; SWAP=1 for one cycle.
  - Loop counter ← new segment's REP; STOP=0; PENDING=0.
  - State → RUN.
- Simultaneous events:
  - LOOP_END in the same cycle as UPDATE_SETTINGS: the loop end is counted against the old state; a SYNC_IDX/EXT request needs a later LOOP_END.
  - LOOP_END that exhausts the count while PENDING: STOP=1, request retained.
  - UPDATE_SETTINGS in the same cycle as a swap: the swap completes, then the request is evaluated against the new SEGMENT.
  - Any non-EXT swap clears auto-alternation.
- Reset mid-request drops the request and returns SEGMENT to 0.

Optional Feature:
- Macro: SEGMENT_TRANSITION_CNT_EN.
- When defined: adds output SWAP_CNT [15:0], incremented on every SWAP (wraps at 0xFFFF→0), reset 0, for the debug output mux.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then REP0=0xFFFF and 10 LOOP_END pulses → SEGMENT=0, STOP=0, SWAP never asserted.
- Same-segment request with REP0=2, then 3 LOOP_END → STOP=1 after the 3rd. Same-segment request again → STOP=0 on the next cycle, no SWAP.
- SYNC_IDX request for seg 1, REP1=0 → PENDING=1; SEGMENT changes the cycle after the next LOOP_END with a 1-cycle SWAP. The following LOOP_END → STOP=1.
- SYS_TIME request, VALUE=1000, SYS_TIME ramping from 990 → SWAP on the cycle after SYS_TIME=1000. Past threshold VALUE=5 → SWAP 2 cycles after UPDATE_SETTINGS.
- GPIO request, VALUE=2; pulse GPIO_IN[1] then GPIO_IN[2] → no swap on bit 1; SWAP 3 cycles after the bit-2 rising edge.
- EXT request with REP0=1, REP1=0 → segments alternate 1,0,1…, swapping after 1 and 2 loops respectively. Mode 0x07 → BAD_MODE=1, state unchanged. Reset while PENDING → all outputs at reset values.
